// File: rtl/alu_sequencer_if.sv
// Request/response handshake and ALU control/result bus of the ALU sequencer.
// The slave modport is the sequencer; the master modport is decode plus the ALU.
interface alu_sequencer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_cin;
  logic [CNTW-1:0]  req_cnt;
  logic             req_dst;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_cin;
  logic             alu_sums;
  logic             alu_subs;
  logic             alu_ands;
  logic             alu_eors;
  logic             alu_ors;
  logic             alu_shftr;
  logic             alu_shftcr;
  logic             alu_dec;
  logic             alu_adloa;
  logic             alu_sboa;
  logic             alu_rst;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;

  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_cout;
  logic             rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, req_cnt, req_dst,
    output req_ready,
    output alu_a, alu_b, alu_cin,
    output alu_sums, alu_subs, alu_ands, alu_eors, alu_ors, alu_shftr, alu_shftcr, alu_dec,
    output alu_adloa, alu_sboa, alu_rst,
    input  alu_res, alu_cout,
    output rsp_valid, rsp_data, rsp_cout, rsp_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, req_cnt, req_dst,
    input  req_ready,
    input  alu_a, alu_b, alu_cin,
    input  alu_sums, alu_subs, alu_ands, alu_eors, alu_ors, alu_shftr, alu_shftcr, alu_dec,
    input  alu_adloa, alu_sboa, alu_rst,
    output alu_res, alu_cout,
    input  rsp_valid, rsp_data, rsp_cout, rsp_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation per request: strobe, read back, optional shift repeat, respond.
// Sole driver of the ALU control lines.
module alu_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  output logic           busy,
  alu_sequencer_if.slave bus
);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpEor  = 4'd3;
  localparam logic [3:0] OpOra  = 4'd4;
  localparam logic [3:0] OpLsr  = 4'd5;
  localparam logic [3:0] OpRor  = 4'd6;
  localparam logic [3:0] OpAddd = 4'd7;
  localparam logic [3:0] OpClr  = 4'd8;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StExec,
    StRead,
    StResp
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [CNTW-1:0]  cnt_q;
  logic             dst_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_cout_q;
  logic             rsp_err_q;

  logic accept;
  logic req_legal;
  logic is_shift;
  logic shift_again;
  logic capture;

  assign req_legal = (bus.req_op <= OpClr);
  assign is_shift  = (op_q == OpLsr) || (op_q == OpRor);
  assign busy      = reset & (state_q != StIdle);

  always_comb begin
    state_d         = state_q;
    accept          = 1'b0;
    shift_again     = 1'b0;
    capture         = 1'b0;
    bus.req_ready   = 1'b0;
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    bus.alu_cin     = 1'b0;
    bus.alu_sums    = 1'b0;
    bus.alu_subs    = 1'b0;
    bus.alu_ands    = 1'b0;
    bus.alu_eors    = 1'b0;
    bus.alu_ors     = 1'b0;
    bus.alu_shftr   = 1'b0;
    bus.alu_shftcr  = 1'b0;
    bus.alu_dec     = 1'b0;
    bus.alu_adloa   = 1'b0;
    bus.alu_sboa    = 1'b0;
    bus.alu_rst     = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_data    = '0;
    bus.rsp_cout    = 1'b0;
    bus.rsp_err     = 1'b0;

    unique case (state_q)
      StInit: begin
        bus.alu_rst = 1'b1;
        state_d     = StIdle;
      end

      StIdle: begin
        bus.req_ready = 1'b1;
        // flush wins over a pending request
        if (!flush && bus.req_valid) begin
          accept  = 1'b1;
          state_d = req_legal ? StExec : StResp;
        end
      end

      StExec: begin
        bus.alu_a   = a_q;
        bus.alu_b   = b_q;
        bus.alu_cin = cin_q;
        unique case (op_q)
          OpAdd:   bus.alu_sums   = 1'b1;
          OpSub:   bus.alu_subs   = 1'b1;
          OpAnd:   bus.alu_ands   = 1'b1;
          OpEor:   bus.alu_eors   = 1'b1;
          OpOra:   bus.alu_ors    = 1'b1;
          OpLsr:   bus.alu_shftr  = 1'b1;
          OpRor:   bus.alu_shftcr = 1'b1;
          OpAddd: begin
            bus.alu_sums = 1'b1;
            bus.alu_dec  = 1'b1;
          end
          OpClr:   bus.alu_rst    = 1'b1;
          default: ;
        endcase
        if (flush) begin
          state_d = StIdle;
        end else begin
          state_d = (op_q == OpClr) ? StResp : StRead;
        end
      end

      StRead: begin
        bus.alu_a     = a_q;
        bus.alu_b     = b_q;
        bus.alu_cin   = cin_q;
        bus.alu_sboa  = ~dst_q;
        bus.alu_adloa = dst_q;
        capture       = 1'b1;
        shift_again   = is_shift && (cnt_q > CNTW'(1)) && !flush;
        if (flush) begin
          state_d = StIdle;
        end else begin
          state_d = shift_again ? StExec : StResp;
        end
      end

      StResp: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = rsp_data_q;
        bus.rsp_cout  = rsp_cout_q;
        bus.rsp_err   = rsp_err_q;
        state_d       = StIdle;
      end

      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StInit;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      cnt_q      <= '0;
      dst_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_cout_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= bus.req_op;
        a_q        <= bus.req_a;
        b_q        <= bus.req_b;
        cin_q      <= bus.req_cin;
        cnt_q      <= (bus.req_cnt == '0) ? CNTW'(1) : bus.req_cnt;
        dst_q      <= bus.req_dst;
        // CLR and illegal requests respond with these zeroed values
        rsp_data_q <= '0;
        rsp_cout_q <= 1'b0;
        rsp_err_q  <= ~req_legal;
      end
      if (capture) begin
        rsp_data_q <= bus.alu_res;
        rsp_cout_q <= bus.alu_cout;
      end
      if (shift_again) begin
        a_q   <= bus.alu_res;
        cin_q <= bus.alu_cout;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU answers the strobes, and a reference
// model computes expected results and latencies directly from the opcode rules.
module tb_alu_sequencer;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNTW  = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic busy;

  int errors = 0;
  int checks = 0;

  alu_sequencer_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  alu_sequencer #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  strobes;
  logic [39:0] all_outs;
  assign strobes = {bus.alu_sums, bus.alu_subs, bus.alu_ands, bus.alu_eors,
                    bus.alu_ors, bus.alu_shftr, bus.alu_shftcr, bus.alu_dec};
  assign all_outs = {bus.req_ready, bus.alu_a, bus.alu_b, bus.alu_cin, strobes,
                     bus.alu_adloa, bus.alu_sboa, bus.rsp_valid, bus.rsp_data,
                     bus.rsp_cout, bus.rsp_err, busy};

  // Behavioural ALU: a strobe latches a result, an output enable puts it on the bus.
  logic [7:0] alu_q;
  logic       alu_c_q;

  function automatic logic [8:0] bcd_add(input logic [7:0] a, input logic [7:0] b,
                                         input logic c);
    logic [4:0] lo, hi;
    lo = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, c};
    if (lo > 5'd9) lo = lo + 5'd6;
    hi = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'd0, lo[4]};
    if (hi > 5'd9) hi = hi + 5'd6;
    return {hi[4], hi[3:0], lo[3:0]};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset || bus.alu_rst) begin
      alu_q   <= 8'h00;
      alu_c_q <= 1'b0;
    end else if (bus.alu_sums && bus.alu_dec) begin
      {alu_c_q, alu_q} <= bcd_add(bus.alu_a, bus.alu_b, bus.alu_cin);
    end else if (bus.alu_sums) begin
      {alu_c_q, alu_q} <= {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_cin};
    end else if (bus.alu_subs) begin
      {alu_c_q, alu_q} <= {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {8'd0, bus.alu_cin};
    end else if (bus.alu_ands) begin
      alu_q <= bus.alu_a & bus.alu_b;  alu_c_q <= 1'b0;
    end else if (bus.alu_eors) begin
      alu_q <= bus.alu_a ^ bus.alu_b;  alu_c_q <= 1'b0;
    end else if (bus.alu_ors) begin
      alu_q <= bus.alu_a | bus.alu_b;  alu_c_q <= 1'b0;
    end else if (bus.alu_shftr) begin
      alu_q <= {1'b0, bus.alu_a[7:1]}; alu_c_q <= bus.alu_a[0];
    end else if (bus.alu_shftcr) begin
      alu_q <= {bus.alu_cin, bus.alu_a[7:1]}; alu_c_q <= bus.alu_a[0];
    end
  end

  assign bus.alu_res  = (bus.alu_sboa | bus.alu_adloa) ? alu_q : 8'h00;
  assign bus.alu_cout = alu_c_q;

  // Reference model: returns {err, cout, data}.
  function automatic logic [9:0] ref_model(input int op, input int a, input int b,
                                           input int cin, input int n);
    int r, d, co, x, da, db;
    d = 0; co = 0;
    case (op)
      0: begin r = a + b + cin; d = r % 256; co = (r > 255) ? 1 : 0; end
      1: begin r = a - b - (1 - cin); d = (r + 256) % 256; co = (r >= 0) ? 1 : 0; end
      2: d = a & b;
      3: d = a ^ b;
      4: d = a | b;
      5: begin d = a >> n; co = (a >> (n - 1)) & 1; end
      6: begin
        x = cin * 256 + a;
        x = ((x >> n) | (x << (9 - n))) & 511;
        d = x % 256; co = x / 256;
      end
      7: begin
        da = (a / 16) * 10 + a % 16;
        db = (b / 16) * 10 + b % 16;
        r = da + db + cin;
        co = (r >= 100) ? 1 : 0;
        r = r % 100;
        d = (r / 10) * 16 + r % 10;
      end
      8: d = 0;
      default: return {1'b1, 9'd0};
    endcase
    return {1'b0, co[0], d[7:0]};
  endfunction

  function automatic int ref_lat(input int op, input int n);
    if (op > 8) return 1;
    if (op == 8) return 2;
    if (op == 5 || op == 6) return 1 + 2 * n;
    return 3;
  endfunction

  function automatic int ref_exec(input int op, input int n);
    if (op >= 8) return 0;
    if (op == 5 || op == 6) return n;
    return 1;
  endfunction

  function automatic logic [7:0] ref_mask(input int op);
    case (op)
      0: return 8'h80;
      1: return 8'h40;
      2: return 8'h20;
      3: return 8'h10;
      4: return 8'h08;
      5: return 8'h04;
      6: return 8'h02;
      7: return 8'h81;
      default: return 8'h00;
    endcase
  endfunction

  // Observations from the most recent do_op.
  int         obs_lat, obs_exec, obs_oe, obs_rst, obs_bad, obs_strobe_cyc, obs_oe_cyc;
  logic [7:0] obs_mask, obs_data, obs_first_a, obs_first_b;
  logic       obs_cout, obs_err, obs_first_cin, obs_after_valid, obs_after_ready;
  logic [7:0] obs_a_trace[$];

  // Entered and left on a negedge, with the sequencer idle on exit.
  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic [2:0] cnt, input logic dst);
    bus.req_op = op; bus.req_a = a; bus.req_b = b;
    bus.req_cin = cin; bus.req_cnt = cnt; bus.req_dst = dst;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    obs_lat = -1; obs_exec = 0; obs_oe = 0; obs_rst = 0; obs_bad = 0;
    obs_strobe_cyc = -1; obs_oe_cyc = -1; obs_mask = 8'h00;
    obs_data = 8'hxx; obs_cout = 1'bx; obs_err = 1'bx;
    obs_a_trace.delete();
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (|strobes) begin
        obs_exec++;
        obs_mask |= strobes;
        obs_a_trace.push_back(bus.alu_a);
        if (obs_exec == 1) begin
          obs_strobe_cyc = c; obs_first_a = bus.alu_a;
          obs_first_b = bus.alu_b; obs_first_cin = bus.alu_cin;
        end
        if ($countones(strobes) > 1 && strobes != 8'h81) obs_bad++;
        if (strobes[0] && !strobes[7]) obs_bad++;
      end
      if (bus.alu_sboa || bus.alu_adloa) begin
        obs_oe++;
        if (obs_oe_cyc < 0) obs_oe_cyc = c;
        if (bus.alu_sboa === dst || bus.alu_adloa !== dst) obs_bad++;
        if (|strobes) obs_bad++;
      end
      if (bus.alu_rst) obs_rst++;
      if (bus.rsp_valid) begin
        obs_lat = c; obs_data = bus.rsp_data; obs_cout = bus.rsp_cout; obs_err = bus.rsp_err;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    obs_after_valid = bus.rsp_valid;
    obs_after_ready = bus.req_ready;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (all_outs !== 40'd0 || bus.alu_rst !== 1'b1) begin
      errors++; $display("FAIL reset_outputs: outs=%h alu_rst=%b, want 0 and 1",
                         all_outs, bus.alu_rst);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.alu_rst !== 1'b1 || bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL init_cycle: alu_rst=%b req_ready=%b, want 1 0",
                         bus.alu_rst, bus.req_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.alu_rst !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_init: alu_rst=%b req_ready=%b busy=%b, want 0 1 0",
                         bus.alu_rst, bus.req_ready, busy);
    end
  endtask

  task automatic test_add();
    do_op(4'd0, 8'h05, 8'h0a, 1'b0, 3'd0, 1'b0);
    checks++;
    if (obs_lat !== 3) begin errors++; $display("FAIL add_latency: got %0d want 3", obs_lat); end
    checks++;
    if ({obs_err, obs_cout, obs_data} !== 10'h00f) begin
      errors++; $display("FAIL add_result: got err=%b cout=%b data=%h want 0 0 0f",
                         obs_err, obs_cout, obs_data);
    end
    checks++;
    if (obs_exec !== 1 || obs_mask !== 8'h80 || obs_strobe_cyc !== 1) begin
      errors++; $display("FAIL add_strobe: cycles=%0d mask=%h at=%0d want 1 80 1",
                         obs_exec, obs_mask, obs_strobe_cyc);
    end
    checks++;
    if (obs_oe !== 1 || obs_oe_cyc !== 2 || obs_bad !== 0) begin
      errors++; $display("FAIL add_sboa: oe=%0d at=%0d bad=%0d want 1 2 0",
                         obs_oe, obs_oe_cyc, obs_bad);
    end
    checks++;
    if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin
      errors++; $display("FAIL add_pulse: after valid=%b ready=%b want 0 1",
                         obs_after_valid, obs_after_ready);
    end
  endtask

  task automatic test_lsr();
    do_op(4'd5, 8'h80, 8'h00, 1'b0, 3'd3, 1'b1);
    checks++;
    if (obs_lat !== 7 || obs_data !== 8'h10 || obs_err !== 1'b0) begin
      errors++; $display("FAIL lsr3: lat=%0d data=%h err=%b want 7 10 0",
                         obs_lat, obs_data, obs_err);
    end
    checks++;
    if (obs_exec !== 3 || obs_oe !== 3 || obs_mask !== 8'h04 || obs_bad !== 0) begin
      errors++; $display("FAIL lsr3_strobes: exec=%0d oe=%0d mask=%h bad=%0d want 3 3 04 0",
                         obs_exec, obs_oe, obs_mask, obs_bad);
    end
    checks++;
    if (obs_a_trace.size() != 3 || obs_a_trace[0] !== 8'h80 || obs_a_trace[1] !== 8'h40 ||
        obs_a_trace[2] !== 8'h20) begin
      errors++; $display("FAIL lsr3_alu_a: got %p want 80 40 20", obs_a_trace);
    end
    for (int k = 0; k < 2; k++) begin
      do_op(4'd5, 8'hb6, 8'h00, 1'b0, 3'(k), 1'b0);
      checks++;
      if (obs_lat !== 3 || obs_data !== 8'h5b || obs_cout !== 1'b0 || obs_exec !== 1) begin
        errors++; $display("FAIL lsr_cnt%0d: lat=%0d data=%h cout=%b exec=%0d want 3 5b 0 1",
                           k, obs_lat, obs_data, obs_cout, obs_exec);
      end
    end
  endtask

  task automatic test_illegal_clr();
    do_op(4'hc, 8'h55, 8'h66, 1'b1, 3'd2, 1'b1);
    checks++;
    if (obs_lat !== 1 || obs_err !== 1'b1 || obs_data !== 8'h00) begin
      errors++; $display("FAIL illegal: lat=%0d err=%b data=%h want 1 1 00",
                         obs_lat, obs_err, obs_data);
    end
    checks++;
    if (obs_exec !== 0 || obs_oe !== 0 || obs_rst !== 0) begin
      errors++; $display("FAIL illegal_quiet: exec=%0d oe=%0d rst=%0d want 0 0 0",
                         obs_exec, obs_oe, obs_rst);
    end
    do_op(4'd8, 8'hff, 8'hff, 1'b1, 3'd0, 1'b0);
    checks++;
    if (obs_lat !== 2 || {obs_err, obs_cout, obs_data} !== 10'h000) begin
      errors++; $display("FAIL clr: lat=%0d err=%b cout=%b data=%h want 2 0 0 00",
                         obs_lat, obs_err, obs_cout, obs_data);
    end
    checks++;
    if (obs_rst !== 1 || obs_exec !== 0 || obs_oe !== 0) begin
      errors++; $display("FAIL clr_strobe: rst=%0d exec=%0d oe=%0d want 1 0 0",
                         obs_rst, obs_exec, obs_oe);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int op, a, b, cin, cnt, n;
      logic [9:0] exp_r;
      op = int'($urandom_range(0, 9));
      if (op == 9) op = int'($urandom_range(9, 15));
      a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255));
      if (op == 7) begin
        a = int'($urandom_range(0, 9)) * 16 + int'($urandom_range(0, 9));
        b = int'($urandom_range(0, 9)) * 16 + int'($urandom_range(0, 9));
      end
      cin = int'($urandom_range(0, 1)); cnt = int'($urandom_range(0, 7));
      n = (cnt == 0) ? 1 : cnt;
      do_op(op[3:0], a[7:0], b[7:0], cin[0], cnt[2:0], 1'($urandom_range(0, 1)));
      exp_r = ref_model(op, a, b, cin, n);
      checks++;
      if ({obs_err, obs_cout, obs_data} !== exp_r) begin
        errors++; $display("FAIL rand%0d_result op=%0d a=%h b=%h cin=%0d n=%0d: got %h want %h",
                           i, op, a, b, cin, n, {obs_err, obs_cout, obs_data}, exp_r);
      end
      checks++;
      if (obs_lat !== ref_lat(op, n)) begin
        errors++; $display("FAIL rand%0d_latency op=%0d n=%0d: got %0d want %0d",
                           i, op, n, obs_lat, ref_lat(op, n));
      end
      checks++;
      if (obs_exec !== ref_exec(op, n) || obs_oe !== ref_exec(op, n) ||
          obs_mask !== ref_mask(op) || obs_bad !== 0) begin
        errors++; $display("FAIL rand%0d_strobes op=%0d: exec=%0d oe=%0d mask=%h bad=%0d want %0d %0d %h 0",
                           i, op, obs_exec, obs_oe, obs_mask, obs_bad,
                           ref_exec(op, n), ref_exec(op, n), ref_mask(op));
      end
      if (op <= 7) begin
        checks++;
        if (obs_first_a !== a[7:0] || obs_first_b !== b[7:0] || obs_first_cin !== cin[0]) begin
          errors++; $display("FAIL rand%0d_operands: got %h %h %b want %h %h %0d",
                             i, obs_first_a, obs_first_b, obs_first_cin, a, b, cin);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[2], rsp_cyc[2], na, nr;
    logic [7:0] rsp_d[2];
    na = 0; nr = 0;
    bus.req_op = 4'd0; bus.req_a = 8'h21; bus.req_b = 8'h13; bus.req_cin = 1'b0;
    bus.req_cnt = 3'd0; bus.req_dst = 1'b0; bus.req_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (bus.rsp_valid && nr < 2) begin rsp_cyc[nr] = c; rsp_d[nr] = bus.rsp_data; nr++; end
      if (bus.req_valid && bus.req_ready && na < 2) begin acc_cyc[na] = c; na++; end
      @(negedge clk);
      if (na == 1) begin bus.req_a = 8'hf0; bus.req_b = 8'h0f; bus.req_cin = 1'b1; end
      if (na == 2) bus.req_valid = 1'b0;
    end
    checks++;
    if (na !== 2 || nr !== 2) begin
      errors++; $display("FAIL b2b_counts: accepts=%0d responses=%0d want 2 2", na, nr);
    end else begin
      checks++;
      if (rsp_cyc[0] - acc_cyc[0] !== 3 || acc_cyc[1] !== rsp_cyc[0] + 1) begin
        errors++; $display("FAIL b2b_accept: acc0=%0d rsp0=%0d acc1=%0d want rsp0=acc0+3 acc1=rsp0+1",
                           acc_cyc[0], rsp_cyc[0], acc_cyc[1]);
      end
      checks++;
      if (rsp_cyc[1] - rsp_cyc[0] !== 4) begin
        errors++; $display("FAIL b2b_spacing: got %0d want 4", rsp_cyc[1] - rsp_cyc[0]);
      end
      checks++;
      if (rsp_d[0] !== 8'h34 || rsp_d[1] !== 8'h00) begin
        errors++; $display("FAIL b2b_data: got %h %h want 34 00", rsp_d[0], rsp_d[1]);
      end
    end
  endtask

  task automatic test_flush();
    int nrsp;
    bus.req_op = 4'd6; bus.req_a = 8'h96; bus.req_b = 8'h00; bus.req_cin = 1'b1;
    bus.req_cnt = 3'd5; bus.req_dst = 1'b1; bus.req_valid = 1'b1;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.alu_adloa !== 1'b1) begin
      errors++; $display("FAIL flush_in_read: adloa=%b want 1", bus.alu_adloa);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (strobes !== 8'h00 || bus.alu_adloa !== 1'b0 || bus.alu_sboa !== 1'b0 ||
        bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle: strobes=%h oe=%b%b valid=%b ready=%b busy=%b want 00 00 0 1 0",
                         strobes, bus.alu_adloa, bus.alu_sboa, bus.rsp_valid, bus.req_ready, busy);
    end
    nrsp = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.rsp_valid) nrsp++;
      @(negedge clk);
    end
    checks++;
    if (nrsp !== 0) begin errors++; $display("FAIL flush_no_rsp: got %0d want 0", nrsp); end
    // flush in IDLE blocks acceptance
    bus.req_op = 4'd0; bus.req_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || strobes !== 8'h00) begin
      errors++; $display("FAIL flush_priority: busy=%b strobes=%h want 0 00", busy, strobes);
    end
    do_op(4'd0, 8'h7f, 8'h01, 1'b1, 3'd0, 1'b0);
    checks++;
    if (obs_lat !== 3 || {obs_err, obs_cout, obs_data} !== 10'h081) begin
      errors++; $display("FAIL flush_next_add: lat=%0d result=%h want 3 081",
                         obs_lat, {obs_err, obs_cout, obs_data});
    end
  endtask

  task automatic test_reset_mid();
    bus.req_op = 4'd1; bus.req_a = 8'h40; bus.req_b = 8'h10; bus.req_cin = 1'b1;
    bus.req_cnt = 3'd0; bus.req_dst = 1'b0; bus.req_valid = 1'b1;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.alu_subs !== 1'b1) begin
      errors++; $display("FAIL mid_exec: subs=%b want 1", bus.alu_subs);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (all_outs !== 40'd0 || bus.alu_rst !== 1'b1) begin
      errors++; $display("FAIL mid_async: outs=%h alu_rst=%b want 0 1", all_outs, bus.alu_rst);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.alu_rst !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_init: alu_rst=%b ready=%b valid=%b want 1 0 0",
                         bus.alu_rst, bus.req_ready, bus.rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.alu_rst !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_idle: alu_rst=%b ready=%b valid=%b want 0 1 0",
                         bus.alu_rst, bus.req_ready, bus.rsp_valid);
    end
    do_op(4'd1, 8'h40, 8'h10, 1'b1, 3'd0, 1'b1);
    checks++;
    if (obs_lat !== 3 || {obs_err, obs_cout, obs_data} !== 10'h130) begin
      errors++; $display("FAIL mid_fresh_sub: lat=%0d result=%h want 3 130",
                         obs_lat, {obs_err, obs_cout, obs_data});
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 4'd0; bus.req_a = 8'h00; bus.req_b = 8'h00;
    bus.req_cin = 1'b0; bus.req_cnt = 3'd0; bus.req_dst = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_lsr();
    test_illegal_clr();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
